// File: rtl/ambient_pkg.sv
// Shared types and constants for the ambient sensor scheduler.
// Holds the FSM state encoding, sensor width helpers and parameter defaults.
package ambient_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_TEMP,
        REQ_HUM,
        REQ_LUM,
        PRESENT,
        WAIT
    } state_t;

    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_PERIOD     = 1000;
    localparam int DEF_TIMEOUT    = 16;

    // Wide enough for the largest legal PERIOD; TIMEOUT fits as well.
    localparam int TIMER_WIDTH = 16;

    localparam int HUM_EXTRA = 1;
    localparam int LUM_EXTRA = 4;

    function automatic int hum_width(input int dw);
        return dw + HUM_EXTRA;
    endfunction

    function automatic int lum_width(input int dw);
        return dw + LUM_EXTRA;
    endfunction

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter that saturates at zero.
// done is high while the loaded count is in its last cycle (or expired).
module period_timer
    import ambient_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign done = (count <= ONE);

endmodule

// File: rtl/sensor_scheduler.sv
// Round-robin sampler of temperature, humidity and luminous sensors.
// Define ACK_TIMEOUT_EN to give up on a silent sensor after TIMEOUT cycles.
module sensor_scheduler
    import ambient_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PERIOD     = DEF_PERIOD,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 enable_i,
    output logic                                 temp_req_o,
    input  logic                                 temp_ack_i,
    input  logic [DATA_WIDTH-1:0]                temp_data_i,
    output logic                                 hum_req_o,
    input  logic                                 hum_ack_i,
    input  logic [hum_width(DATA_WIDTH)-1:0]     hum_data_i,
    output logic                                 lum_req_o,
    input  logic                                 lum_ack_i,
    input  logic [lum_width(DATA_WIDTH)-1:0]     lum_data_i,
    output logic [DATA_WIDTH-1:0]                temperature_o,
    output logic [hum_width(DATA_WIDTH)-1:0]     humidity_o,
    output logic [lum_width(DATA_WIDTH)-1:0]     luminous_intensity_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic                                 busy_o,
    output logic [2:0]                           err_o
);

    localparam int HW = hum_width(DATA_WIDTH);
    localparam int LW = lum_width(DATA_WIDTH);

    localparam logic [TIMER_WIDTH-1:0] PERIOD_V  = TIMER_WIDTH'(PERIOD);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_V = TIMER_WIDTH'(TIMEOUT);

    state_t state, state_d;

    logic                  stop, stop_d;
    logic [DATA_WIDTH-1:0] temp_d;
    logic [HW-1:0]         hum_d;
    logic [LW-1:0]         lum_d;

    logic temp_hit, hum_hit, lum_hit, xfer;
    logic temp_to, hum_to, lum_to;
    logic tmr_arm, tmr_load, tmr_done;
    logic [TIMER_WIDTH-1:0] tmr_value;

    assign temp_hit = temp_req_o && temp_ack_i;
    assign hum_hit  = hum_req_o && hum_ack_i;
    assign lum_hit  = lum_req_o && lum_ack_i;
    assign xfer     = valid_o && ready_i;

`ifdef ACK_TIMEOUT_EN
    assign temp_to = temp_req_o && !temp_ack_i && tmr_done;
    assign hum_to  = hum_req_o && !hum_ack_i && tmr_done;
    assign lum_to  = lum_req_o && !lum_ack_i && tmr_done;
    assign tmr_arm = state_d inside {REQ_TEMP, REQ_HUM, REQ_LUM, WAIT};
`else
    assign temp_to = 1'b0;
    assign hum_to  = 1'b0;
    assign lum_to  = 1'b0;
    assign tmr_arm = (state_d == WAIT);
`endif

    // The timer is reloaded on every entry into a state that needs it.
    assign tmr_load  = tmr_arm && (state_d != state);
    assign tmr_value = (state_d == WAIT) ? PERIOD_V : TIMEOUT_V;

    period_timer #(
        .WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk  (clk_i),
        .rst  (reset_i),
        .load (tmr_load),
        .value(tmr_value),
        .done (tmr_done)
    );

    always_comb begin
        state_d = state;
        stop_d  = stop;
        temp_d  = temperature_o;
        hum_d   = humidity_o;
        lum_d   = luminous_intensity_o;
        unique case (state)
            IDLE: begin
                if (enable_i) state_d = REQ_TEMP;
            end
            REQ_TEMP: begin
                if (temp_hit) begin
                    temp_d  = temp_data_i;
                    state_d = REQ_HUM;
                end else if (temp_to) begin
                    state_d = REQ_HUM;
                end
            end
            REQ_HUM: begin
                if (hum_hit) begin
                    hum_d   = hum_data_i;
                    state_d = REQ_LUM;
                end else if (hum_to) begin
                    state_d = REQ_LUM;
                end
            end
            REQ_LUM: begin
                if (lum_hit) begin
                    lum_d   = lum_data_i;
                    state_d = PRESENT;
                end else if (lum_to) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (xfer) state_d = (stop || !enable_i) ? IDLE : WAIT;
            end
            WAIT: begin
                if (tmr_done) state_d = enable_i ? REQ_TEMP : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A round started is always finished; a drop of enable only
        // suppresses the following WAIT.
        if (state != IDLE && state != WAIT && !enable_i) stop_d = 1'b1;
        if (state_d == REQ_TEMP && state != REQ_TEMP) stop_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state                <= IDLE;
            stop                 <= 1'b0;
            temp_req_o           <= 1'b0;
            hum_req_o            <= 1'b0;
            lum_req_o            <= 1'b0;
            valid_o              <= 1'b0;
            busy_o               <= 1'b0;
            temperature_o        <= '0;
            humidity_o           <= '0;
            luminous_intensity_o <= '0;
        end else begin
            state                <= state_d;
            stop                 <= stop_d;
            temp_req_o           <= (state_d == REQ_TEMP);
            hum_req_o            <= (state_d == REQ_HUM);
            lum_req_o            <= (state_d == REQ_LUM);
            valid_o              <= (state_d == PRESENT);
            busy_o               <= (state_d != IDLE);
            temperature_o        <= temp_d;
            humidity_o           <= hum_d;
            luminous_intensity_o <= lum_d;
        end
    end

`ifdef ACK_TIMEOUT_EN
    logic [2:0] err_d;

    always_comb begin
        err_d = err_o | {lum_to, hum_to, temp_to};
        if (state_d == REQ_TEMP && state != REQ_TEMP) err_d = '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) err_o <= '0;
        else         err_o <= err_d;
    end
`else
    assign err_o = '0;
`endif

endmodule

// File: tb/tb_sensor_scheduler.sv
// Scoreboard bench for sensor_scheduler: expected sample sets are queued
// when a round is launched and retired when the controller takes the set.
module tb_sensor_scheduler;

    localparam int DW  = 6;
    localparam int HW  = DW + 1;
    localparam int LW  = DW + 4;
    localparam int PER = 8;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          temp_req, temp_ack;
    logic [DW-1:0] temp_data;
    logic          hum_req, hum_ack;
    logic [HW-1:0] hum_data;
    logic          lum_req, lum_ack;
    logic [LW-1:0] lum_data;
    logic [DW-1:0] temperature;
    logic [HW-1:0] humidity;
    logic [LW-1:0] luminous;
    logic          valid, ready, busy;
    logic [2:0]    err;

    typedef struct {
        int t;
        int h;
        int l;
        int e;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int xfers = 0;
    int pushes = 0;

    logic tie;
    int dly_t, dly_h, dly_l;
    int cnt_t, cnt_h, cnt_l;

    sensor_scheduler #(
        .DATA_WIDTH(DW),
        .PERIOD    (PER),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i               (clk),
        .reset_i             (rst),
        .enable_i            (enable),
        .temp_req_o          (temp_req),
        .temp_ack_i          (temp_ack),
        .temp_data_i         (temp_data),
        .hum_req_o           (hum_req),
        .hum_ack_i           (hum_ack),
        .hum_data_i          (hum_data),
        .lum_req_o           (lum_req),
        .lum_ack_i           (lum_ack),
        .lum_data_i          (lum_data),
        .temperature_o       (temperature),
        .humidity_o          (humidity),
        .luminous_intensity_o(luminous),
        .valid_o             (valid),
        .ready_i             (ready),
        .busy_o              (busy),
        .err_o               (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int t, input int h, input int l);
        temp_data = DW'(t);
        hum_data  = HW'(h);
        lum_data  = LW'(l);
    endtask

    task automatic expect_set(input int t, input int h, input int l, input int e);
        exp_t x;
        x.t = t;
        x.h = h;
        x.l = l;
        x.e = e;
        sb.push_back(x);
        pushes++;
    endtask

    // Sensors: ack after dly cycles of req, or constantly when tied.
    always @(negedge clk) begin
        if (temp_req) begin
            temp_ack = tie || (cnt_t >= dly_t);
            cnt_t++;
        end else begin
            temp_ack = tie;
            cnt_t = 0;
        end
        if (hum_req) begin
            hum_ack = tie || (cnt_h >= dly_h);
            cnt_h++;
        end else begin
            hum_ack = tie;
            cnt_h = 0;
        end
        if (lum_req) begin
            lum_ack = tie || (cnt_l >= dly_l);
            cnt_l++;
        end else begin
            lum_ack = tie;
            cnt_l = 0;
        end
    end

    // The set is taken on the next rising edge.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (!rst && valid && ready) begin
            xfers++;
            chk("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("temperature", int'(temperature), x.t);
                chk("humidity", int'(humidity), x.h);
                chk("luminous", int'(luminous), x.l);
                chk("err", int'(err), x.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        int hi;
        int hold;
        int x0;
        rst = 1'b1;
        enable = 1'b0;
        ready = 1'b0;
        tie = 1'b0;
        dly_t = 0;
        dly_h = 0;
        dly_l = 0;
        cnt_t = 0;
        cnt_h = 0;
        cnt_l = 0;
        temp_ack = 1'b0;
        hum_ack = 1'b0;
        lum_ack = 1'b0;
        set_data(0, 0, 0);
        tick();
        tick();
        chk("rst_reqs", int'({temp_req, hum_req, lum_req}), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_data", int'({temperature, humidity, luminous}), 0);
        rst = 1'b0;
        tick();

        // Acks tied high, ready high: 3-cycle round, then PERIOD of WAIT.
        tie = 1'b1;
        ready = 1'b1;
        set_data(21, 55, 600);
        expect_set(21, 55, 600, 0);
        enable = 1'b1;
        tick();
        chk("s1_temp_req", int'(temp_req), 1);
        n = 1;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        chk("s1_valid_lat", n, 4);
        tick();
        chk("s1_wait_busy", int'(busy), 1);
        chk("s1_wait_valid", int'(valid), 0);
        n = 1;
        while (!temp_req && n < 200) begin
            tick();
            n++;
        end
        chk("s1_period", n, PER + 1);

        // Enable drops in REQ_TEMP: round finishes, then straight to IDLE.
        enable = 1'b0;
        expect_set(21, 55, 600, 0);
        n = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        chk("s1b_valid_lat", n, 3);
        tick();
        chk("s1b_idle_busy", int'(busy), 0);
        tie = 1'b0;
        tick();

        // Humidity ack delayed by 5 cycles.
        dly_h = 5;
        set_data(7, 100, 1023);
        expect_set(7, 100, 1023, 0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        n = 1;
        hi = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
            if (hum_req) hi++;
        end
        chk("s2_hum_req_len", hi, 6);
        chk("s2_valid_lat", n, 9);
        tick();
        chk("s2_idle_busy", int'(busy), 0);
        dly_h = 0;

        // Ready held low for 10 PRESENT cycles.
        ready = 1'b0;
        set_data(33, 77, 512);
        expect_set(33, 77, 512, 0);
        x0 = xfers;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        n = 1;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        chk("s3_valid_lat", n, 4);
        hold = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) ready = 1'b1;
            if (valid && temperature == 33 && humidity == 77 && luminous == 512)
                hold++;
            if (i < 10) tick();
        end
        tick();
        chk("s3_hold", hold, 11);
        chk("s3_valid_drop", int'(valid), 0);
        chk("s3_single_xfer", xfers - x0, 1);

        // Enable dropped while humidity is being requested.
        dly_h = 3;
        set_data(1, 2, 3);
        expect_set(1, 2, 3, 0);
        enable = 1'b1;
        n = 0;
        while (!hum_req && n < 50) begin
            tick();
            n++;
        end
        chk("s4_hum_req", int'(hum_req), 1);
        enable = 1'b0;
        n = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        chk("s4_valid", int'(valid), 1);
        tick();
        chk("s4_idle_busy", int'(busy), 0);
        repeat (PER + 2) tick();
        chk("s4_still_idle", int'({busy, temp_req}), 0);
        dly_h = 0;

        // Reset in the middle of REQ_LUM.
        dly_l = 100000;
        set_data(9, 9, 9);
        enable = 1'b1;
        n = 0;
        while (!lum_req && n < 50) begin
            tick();
            n++;
        end
        chk("s5_lum_req", int'(lum_req), 1);
        tick();
        #1;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        chk("s5_async_reqs", int'({temp_req, hum_req, lum_req}), 0);
        chk("s5_async_busy", int'(busy), 0);
        chk("s5_async_valid", int'(valid), 0);
        chk("s5_async_data", int'({temperature, humidity, luminous}), 0);
        chk("s5_async_err", int'(err), 0);
        tick();
        rst = 1'b0;
        dly_l = 0;
        tick();
        set_data(4, 5, 6);
        expect_set(4, 5, 6, 0);
        enable = 1'b1;
        tick();
        chk("s5_restart", int'({temp_req, hum_req, lum_req}), 4);
        enable = 1'b0;
        n = 1;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        chk("s5_valid_lat", n, 4);
        tick();

`ifdef ACK_TIMEOUT_EN
        // Luminous sensor silent: timeout keeps the previous value.
        dly_l = 100000;
        set_data(11, 12, 13);
        expect_set(11, 12, 6, 4);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        n = 1;
        hi = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
            if (lum_req) hi++;
        end
        chk("to_lum_req_len", hi, TO);
        chk("to_valid_lat", n, 3 + TO);
        tick();
        dly_l = 0;
        expect_set(11, 12, 13, 0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("to_err_clear", int'(err), 0);
        n = 1;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        chk("to_valid_lat2", n, 4);
        tick();
`endif

        repeat (3) tick();
        chk("sb_left", sb.size(), 0);
        chk("xfer_count", xfers, pushes);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sensor_scheduler.md
SENSOR_SCHEDULER -- requirements
Module: sensor_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 6: base sensor width; temperature DATA_WIDTH, humidity DATA_WIDTH+1, luminous DATA_WIDTH+4 bits.
REQ-002 Parameter PERIOD, default 1000: idle cycles between sampling rounds, legal range 1..65535.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles to wait for a sensor ack, legal range 1..255.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 enable_i  in  1  permits new sampling rounds.
REQ-008 temp_req_o / temp_ack_i / temp_data_i  out/in/in  1/1/DATA_WIDTH  temperature sensor handshake.
REQ-009 hum_req_o / hum_ack_i / hum_data_i  out/in/in  1/1/DATA_WIDTH+1  humidity sensor handshake.
REQ-010 lum_req_o / lum_ack_i / lum_data_i  out/in/in  1/1/DATA_WIDTH+4  luminous sensor handshake.
REQ-011 temperature_o, humidity_o, luminous_intensity_o  out  as above  sample set to the ambient controller.
REQ-012 valid_o / ready_i  out/in  1/1  sample-set handshake with the ambient controller.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 err_o  out  3  per-sensor timeout flags {lum,hum,temp} for the presented set.

Function
REQ-015 The FSM SHALL use the states IDLE, REQ_TEMP, REQ_HUM, REQ_LUM, PRESENT and WAIT; all outputs are registered.
REQ-016 IDLE->REQ_TEMP when enable_i=1; temp_req_o rises the cycle after enable_i is sampled high.
REQ-017 In REQ_x, x_req_o SHALL be held high until x_ack_i is sampled high; x_data_i is captured that edge, x_req_o drops next cycle together with the move to the next state.
REQ-018 Acks arriving while the matching req is low SHALL be ignored.
REQ-019 The chain is REQ_TEMP->REQ_HUM->REQ_LUM->PRESENT; with ack tied high a round takes 3 cycles and valid_o rises on the 4th.
REQ-020 In PRESENT, valid_o=1 with data stable until ready_i=1 is sampled; the transfer completes on that edge and valid_o drops next cycle.
REQ-021 ready_i may be high before valid_o; the transfer then completes in the first PRESENT cycle.
REQ-022 After the transfer, WAIT counts PERIOD cycles, then goes to REQ_TEMP if enable_i=1, else IDLE.
REQ-023 enable_i=0 mid-round SHALL NOT abort the round: it completes through PRESENT and then returns to IDLE without waiting.
REQ-024 The period counter SHALL saturate without wrapping; PERIOD=1 gives exactly one WAIT cycle.

Reset
REQ-025 reset_i asserted SHALL force IDLE, all req_o=0, valid_o=0, busy_o=0, err_o=0 and data outputs=0 immediately, including mid-round.
REQ-026 After deassertion, the first request SHALL follow REQ-016.

Configuration
REQ-027 With ACK_TIMEOUT_EN defined, a REQ_x state with no ack for TIMEOUT cycles SHALL drop x_req_o, keep the previous x data, set err_o bit x and advance.
REQ-028 err_o SHALL be cleared on entry to REQ_TEMP and updated over the round.
REQ-029 Without ACK_TIMEOUT_EN, REQ_x SHALL wait indefinitely, err_o is tied 0 and no timeout counter is built.

Structure
REQ-030 Package ambient_pkg SHALL hold the FSM state enum, the width constants derived from DATA_WIDTH, and the default PERIOD/TIMEOUT.
REQ-031 Sub-module period_timer (load, count-down, done) SHALL be used for both the WAIT count and the ack timeout.

Verification
REQ-032 enable=1, all acks tied high, ready=1, data 21/55/600 -> valid_o on the 4th cycle after enable, outputs 21/55/600, next temp_req_o after PERIOD WAIT cycles.
REQ-033 hum_ack delayed 5 cycles -> hum_req_o high for 6 cycles, the set is presented 5 cycles later than in REQ-032, err_o=0.
REQ-034 ready_i low for 10 cycles in PRESENT -> valid_o and data held stable for 11 cycles, a single transfer.
REQ-035 ACK_TIMEOUT_EN, TIMEOUT=16, lum never acks -> lum_req_o drops after 16 cycles, err_o=3'b100, previous luminous value presented.
REQ-036 enable dropped during REQ_HUM -> the round completes, the set is transferred, then IDLE with busy_o=0 and no WAIT.
REQ-037 reset_i pulsed during REQ_LUM -> all outputs are 0 asynchronously and the next round restarts at temperature.
